issue_sched: RTL and testbench
==============================

ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 4, meaning the number of reservation-station entries (power of two, 2..8).
REQ-002 The block SHALL have parameter TAG_W, default 6, meaning the physical-register tag width.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous and active-high.
REQ-005 Port flush  input  1  synchronous pipeline flush; discards all entries.
REQ-006 Port disp_valid  input  1  dispatch request from the decode/rename stage.
REQ-007 Port disp_ready  output  1  a free entry exists.
REQ-008 Port disp_alu_op  input  3  ALU opcode: 000 add, 001 sub, 010 xor, 011 sra, 100 and.
REQ-009 Port disp_alu_src  input  1  1 = operand 2 is the immediate.
REQ-010 Port disp_src1_tag, disp_src2_tag, disp_dst_tag  input  TAG_W each  source and destination tags.
REQ-011 Port disp_src1_rdy, disp_src2_rdy  input  1 each  source value already available.
REQ-012 Port disp_imm  input  32  immediate.
REQ-013 Port cdb_valid  input  1; cdb_tag  input  TAG_W  result broadcast (wakeup).
REQ-014 Port iss_valid  output  1  an instruction is offered to the ALU.
REQ-015 Port iss_ready  input  1  ALU accepts the offered instruction.
REQ-016 Port iss_alu_op (3), iss_alu_src (1), iss_src1_tag, iss_src2_tag, iss_dst_tag (TAG_W), iss_imm (32)  outputs  fields of the offered entry.

Function
REQ-017 Each entry SHALL hold valid, alu_op, alu_src, three tags, imm and two source-ready bits.
REQ-018 Dispatch SHALL occur on an edge where disp_valid & disp_ready & ~flush, writing the lowest-index free entry.
REQ-019 disp_ready SHALL be 1 exactly when at least one entry is invalid, computed from current state only; a same-cycle issue does not free space for that cycle's dispatch.
REQ-020 On dispatch, src2 ready SHALL be stored as 1 when disp_alu_src = 1, regardless of disp_src2_rdy.
REQ-021 On dispatch, a source whose tag equals cdb_tag while cdb_valid = 1 SHALL be stored as ready.
REQ-022 On every edge with cdb_valid = 1, every valid entry SHALL set each source-ready bit whose tag equals cdb_tag; multiple entries and both sources may wake together.
REQ-023 An entry SHALL be eligible when valid and both source-ready bits are set; a wakeup takes effect in the cycle after the broadcast edge.
REQ-024 iss_valid SHALL be 1 when any entry is eligible, driven combinationally from stored state; iss_* fields SHALL come from the oldest eligible entry (earliest dispatched), tracked by an ENTRIES x ENTRIES age matrix.
REQ-025 When iss_valid = 0, all iss_* data outputs SHALL be 0.
REQ-026 The offered entry SHALL be invalidated on an edge where iss_valid & iss_ready; otherwise the offer is held stable unless an older entry becomes eligible.
REQ-027 Simultaneous dispatch and issue SHALL both take effect on the same edge.
REQ-028 flush = 1 SHALL invalidate all entries on that edge and take priority over dispatch, issue and wakeup.
REQ-029 Throughput SHALL be one dispatch and one issue per cycle; dispatch-to-issue latency for an operand-ready instruction SHALL be one cycle.

Reset
REQ-030 While reset = 1, all entries SHALL be invalid and the age matrix cleared, independent of clk.
REQ-031 Outputs after reset: disp_ready = 1, iss_valid = 0, all iss_* data = 0.
REQ-032 Reset asserted mid-operation SHALL discard all held entries immediately; no issue SHALL occur in the first cycle after deassertion.

Structure
REQ-033 ALU opcode encodings and default tag width SHALL live in a shared package, cpu_pkg, used by decode, scheduler and ALU.
REQ-034 Oldest-ready selection SHALL be a sub-module, age_select, taking the eligible vector and age matrix and returning a one-hot grant.

Verification
REQ-035 Reset, then dispatch add dst=5 with both sources ready, iss_ready=1 -> iss_valid=1 next cycle, iss_dst_tag=5, iss_alu_op=000.
REQ-036 Dispatch sub src1=7 not ready; cdb_valid=1, cdb_tag=7 two cycles later -> iss_valid rises the cycle after the broadcast edge.
REQ-037 Fill 4 entries with sources waiting on tag 9 -> disp_ready=0; broadcast tag 9 -> all four issue oldest-first over four cycles with iss_ready=1.
REQ-038 Dispatch entries A (not ready) then B (ready); wake A -> while both are eligible, A is offered first.
REQ-039 Full, iss_ready=1, disp_valid=1 -> no dispatch on that edge; dispatch accepted on the next edge.
REQ-040 3 entries valid, assert flush with disp_valid=1 -> next cycle iss_valid=0, disp_ready=1, new instruction not stored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encodings and the default physical-tag width.
package cpu_pkg;

    localparam int TAG_W_DEF = 6;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_XOR = 3'b010,
        ALU_SRA = 3'b011,
        ALU_AND = 3'b100
    } alu_op_e;

endpackage

// File: rtl/age_select.sv
// Oldest-ready picker: grants the eligible entry that no other eligible entry is older than.
module age_select #(
    parameter int ENTRIES = 4
) (
    input  logic [ENTRIES-1:0]         elig_i,
    // bit (j*ENTRIES + i) set means entry j is older than entry i
    input  logic [ENTRIES*ENTRIES-1:0] age_i,
    output logic [ENTRIES-1:0]         grant_o
);

    logic [ENTRIES-1:0] blk;

    always_comb begin
        blk     = '0;
        grant_o = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != i && elig_i[j] && age_i[j*ENTRIES+i]) blk[i] = 1'b1;
            end
            grant_o[i] = elig_i[i] & ~blk[i];
        end
    end

endmodule

// File: rtl/issue_sched.sv
// Single-issue reservation station: in-order age tracking, CDB wakeup, oldest-ready issue to one ALU.
module issue_sched
    import cpu_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [2:0]       disp_alu_op,
    input  logic             disp_alu_src,
    input  logic [TAG_W-1:0] disp_src1_tag,
    input  logic [TAG_W-1:0] disp_src2_tag,
    input  logic [TAG_W-1:0] disp_dst_tag,
    input  logic             disp_src1_rdy,
    input  logic             disp_src2_rdy,
    input  logic [31:0]      disp_imm,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [2:0]       iss_alu_op,
    output logic             iss_alu_src,
    output logic [TAG_W-1:0] iss_src1_tag,
    output logic [TAG_W-1:0] iss_src2_tag,
    output logic [TAG_W-1:0] iss_dst_tag,
    output logic [31:0]      iss_imm
);

    logic [ENTRIES-1:0]                 vld_q, vld_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [ENTRIES-1:0]                 src_q, src_d;
    logic [ENTRIES-1:0][2:0]            op_q, op_d;
    logic [ENTRIES-1:0][TAG_W-1:0]      t1_q, t1_d, t2_q, t2_d, td_q, td_d;
    logic [ENTRIES-1:0][31:0]           imm_q, imm_d;
    // age_q[j][i] set means entry j was dispatched before entry i
    logic [ENTRIES-1:0][ENTRIES-1:0]    age_q, age_d;

    logic [ENTRIES-1:0] elig, grant, free, alloc;
    logic               do_disp, do_iss;

    assign elig       = vld_q & rdy1_q & rdy2_q;
    assign iss_valid  = |elig;
    assign free       = ~vld_q;
    assign alloc      = free & (~free + 1'b1);
    assign disp_ready = |free;
    assign do_disp    = disp_valid & disp_ready;
    assign do_iss     = iss_valid & iss_ready;

    age_select #(.ENTRIES(ENTRIES)) u_age_select (
        .elig_i  (elig),
        .age_i   (age_q),
        .grant_o (grant)
    );

    always_comb begin
        iss_alu_op   = '0;
        iss_alu_src  = 1'b0;
        iss_src1_tag = '0;
        iss_src2_tag = '0;
        iss_dst_tag  = '0;
        iss_imm      = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant[i]) begin
                iss_alu_op   = iss_alu_op   | op_q[i];
                iss_alu_src  = iss_alu_src  | src_q[i];
                iss_src1_tag = iss_src1_tag | t1_q[i];
                iss_src2_tag = iss_src2_tag | t2_q[i];
                iss_dst_tag  = iss_dst_tag  | td_q[i];
                iss_imm      = iss_imm      | imm_q[i];
            end
        end
    end

    always_comb begin
        vld_d  = vld_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        src_d  = src_q;
        op_d   = op_q;
        t1_d   = t1_q;
        t2_d   = t2_q;
        td_d   = td_q;
        imm_d  = imm_q;
        age_d  = age_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (cdb_valid && vld_q[i] && t1_q[i] == cdb_tag) rdy1_d[i] = 1'b1;
            if (cdb_valid && vld_q[i] && t2_q[i] == cdb_tag) rdy2_d[i] = 1'b1;
        end
        if (do_iss) vld_d = vld_d & ~grant;
        for (int i = 0; i < ENTRIES; i++) begin
            if (do_disp && alloc[i]) begin
                vld_d[i]  = 1'b1;
                op_d[i]   = disp_alu_op;
                src_d[i]  = disp_alu_src;
                t1_d[i]   = disp_src1_tag;
                t2_d[i]   = disp_src2_tag;
                td_d[i]   = disp_dst_tag;
                imm_d[i]  = disp_imm;
                rdy1_d[i] = disp_src1_rdy | (cdb_valid && disp_src1_tag == cdb_tag);
                rdy2_d[i] = disp_alu_src | disp_src2_rdy | (cdb_valid && disp_src2_tag == cdb_tag);
                // newcomer is younger than everyone: clear its row, set its column
                for (int j = 0; j < ENTRIES; j++) begin
                    age_d[i][j] = 1'b0;
                    age_d[j][i] = (j != i);
                end
            end
        end
        if (flush) vld_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            src_q  <= '0;
            op_q   <= '0;
            t1_q   <= '0;
            t2_q   <= '0;
            td_q   <= '0;
            imm_q  <= '0;
            age_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d;
            src_q  <= src_d;
            op_q   <= op_d;
            t1_q   <= t1_d;
            t2_q   <= t2_d;
            td_q   <= td_d;
            imm_q  <= imm_d;
            age_q  <= age_d;
        end
    end

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: dispatch, wakeup, age ordering, full/flush/reset corners.
module tb_issue_sched;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, disp_valid, disp_ready, disp_alu_src;
    logic [2:0]  disp_alu_op, iss_alu_op;
    logic [5:0]  disp_src1_tag, disp_src2_tag, disp_dst_tag, cdb_tag;
    logic        disp_src1_rdy, disp_src2_rdy, cdb_valid, iss_valid, iss_ready, iss_alu_src;
    logic [5:0]  iss_src1_tag, iss_src2_tag, iss_dst_tag;
    logic [31:0] disp_imm, iss_imm;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    issue_sched #(.ENTRIES(4), .TAG_W(6)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_alu_op(disp_alu_op), .disp_alu_src(disp_alu_src),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag), .disp_dst_tag(disp_dst_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy), .disp_imm(disp_imm),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_alu_op(iss_alu_op), .iss_alu_src(iss_alu_src),
        .iss_src1_tag(iss_src1_tag), .iss_src2_tag(iss_src2_tag), .iss_dst_tag(iss_dst_tag),
        .iss_imm(iss_imm)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drv(input logic [2:0] op, input logic src, input logic [5:0] t1, input logic r1,
                       input logic [5:0] t2, input logic r2, input logic [5:0] dst, input logic [31:0] imm);
        disp_valid = 1'b1; disp_alu_op = op; disp_alu_src = src;
        disp_src1_tag = t1; disp_src1_rdy = r1; disp_src2_tag = t2; disp_src2_rdy = r2;
        disp_dst_tag = dst; disp_imm = imm;
    endtask

    task automatic idle();
        disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; iss_ready = 1'b0; cdb_tag = '0;
        idle(); drv(3'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0); disp_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        tests++; if (disp_ready !== 1'b1) begin fails++; $display("FAIL reset_disp_ready got %0b want 1", disp_ready); end
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL reset_iss_valid got %0b want 0", iss_valid); end
        tests++; if (iss_dst_tag !== 6'd0 || iss_imm !== 32'd0 || iss_alu_op !== 3'd0)
            begin fails++; $display("FAIL reset_iss_data got dst=%0d imm=%0d op=%0d want 0", iss_dst_tag, iss_imm, iss_alu_op); end
    endtask

    task automatic test_basic();
        iss_ready = 1'b1;
        drv(ALU_ADD, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5, 32'd0);
        tick(); idle();
        tests++; if (iss_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b want 1", iss_valid); end
        tests++; if (iss_dst_tag !== 6'd5) begin fails++; $display("FAIL basic_dst got %0d want 5", iss_dst_tag); end
        tests++; if (iss_alu_op !== 3'b000) begin fails++; $display("FAIL basic_op got %0d want 0", iss_alu_op); end
        tick();
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL basic_drained got %0b want 0", iss_valid); end
    endtask

    task automatic test_wakeup();
        iss_ready = 1'b1;
        drv(ALU_SUB, 1'b0, 6'd7, 1'b0, 6'd3, 1'b1, 6'd8, 32'd0);
        tick(); idle();
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL wake_wait got %0b want 0", iss_valid); end
        tick();
        cdb_valid = 1'b1; cdb_tag = 6'd7; #1;
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL wake_same_cycle got %0b want 0", iss_valid); end
        tick(); idle();
        tests++; if (iss_valid !== 1'b1 || iss_dst_tag !== 6'd8 || iss_alu_op !== 3'b001)
            begin fails++; $display("FAIL wake_issue got v=%0b dst=%0d op=%0d want 1/8/1", iss_valid, iss_dst_tag, iss_alu_op); end
        tick();
    endtask

    task automatic test_fill();
        iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drv(ALU_XOR, 1'b1, 6'd9, 1'b0, 6'd0, 1'b0, 6'(10 + k), 32'(k * 4));
            tick();
        end
        idle();
        tests++; if (disp_ready !== 1'b0) begin fails++; $display("FAIL fill_ready got %0b want 0", disp_ready); end
        tests++; if (iss_valid !== 1'b0 || iss_imm !== 32'd0) begin fails++; $display("FAIL fill_blocked got v=%0b imm=%0d want 0/0", iss_valid, iss_imm); end
        cdb_valid = 1'b1; cdb_tag = 6'd9;
        tick(); idle(); iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests++; if (iss_valid !== 1'b1 || iss_dst_tag !== 6'(10 + k) || iss_imm !== 32'(k * 4))
                begin fails++; $display("FAIL fill_order%0d got v=%0b dst=%0d imm=%0d want 1/%0d/%0d", k, iss_valid, iss_dst_tag, iss_imm, 10 + k, k * 4); end
            tick();
        end
        tests++; if (iss_valid !== 1'b0 || disp_ready !== 1'b1) begin fails++; $display("FAIL fill_empty got v=%0b r=%0b want 0/1", iss_valid, disp_ready); end
    endtask

    task automatic test_age();
        iss_ready = 1'b0;
        drv(ALU_AND, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd30, 32'd0); tick();
        drv(ALU_ADD, 1'b0, 6'd20, 1'b0, 6'd2, 1'b1, 6'd21, 32'd0); tick();
        idle();
        tests++; if (iss_dst_tag !== 6'd30) begin fails++; $display("FAIL age_first got %0d want 30", iss_dst_tag); end
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL age_gap got %0b want 0", iss_valid); end
        // B lands in the lower-index slot freed above, but is younger than A
        drv(ALU_SRA, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd22, 32'd0); tick(); idle();
        tests++; if (iss_dst_tag !== 6'd22) begin fails++; $display("FAIL age_only_b got %0d want 22", iss_dst_tag); end
        cdb_valid = 1'b1; cdb_tag = 6'd20; tick(); idle();
        tests++; if (iss_dst_tag !== 6'd21) begin fails++; $display("FAIL age_a_first got %0d want 21", iss_dst_tag); end
        iss_ready = 1'b1; tick();
        tests++; if (iss_dst_tag !== 6'd22 || iss_alu_op !== 3'b011) begin fails++; $display("FAIL age_b_second got dst=%0d op=%0d want 22/3", iss_dst_tag, iss_alu_op); end
        tick();
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL age_drained got %0b want 0", iss_valid); end
    endtask

    task automatic test_full();
        iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drv(ALU_ADD, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'(40 + k), 32'd0); tick();
        end
        tests++; if (disp_ready !== 1'b0 || iss_dst_tag !== 6'd40) begin fails++; $display("FAIL full_state got r=%0b dst=%0d want 0/40", disp_ready, iss_dst_tag); end
        iss_ready = 1'b1;
        drv(ALU_ADD, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd44, 32'd0);
        tick(); iss_ready = 1'b0;
        tests++; if (disp_ready !== 1'b1 || iss_dst_tag !== 6'd41) begin fails++; $display("FAIL full_no_disp got r=%0b dst=%0d want 1/41", disp_ready, iss_dst_tag); end
        tick(); idle();
        tests++; if (disp_ready !== 1'b0) begin fails++; $display("FAIL full_accept got %0b want 0", disp_ready); end
        iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests++; if (iss_dst_tag !== 6'(41 + k)) begin fails++; $display("FAIL full_drain%0d got %0d want %0d", k, iss_dst_tag, 41 + k); end
            tick();
        end
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL full_empty got %0b want 0", iss_valid); end
    endtask

    task automatic test_back_to_back();
        iss_ready = 1'b1;
        drv(ALU_ADD, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd60, 32'd0); tick();
        tests++; if (iss_dst_tag !== 6'd60) begin fails++; $display("FAIL b2b_first got %0d want 60", iss_dst_tag); end
        drv(ALU_ADD, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd61, 32'd0); tick(); idle();
        tests++; if (iss_valid !== 1'b1 || iss_dst_tag !== 6'd61) begin fails++; $display("FAIL b2b_second got v=%0b dst=%0d want 1/61", iss_valid, iss_dst_tag); end
        tick();
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %0b want 0", iss_valid); end
    endtask

    task automatic test_disp_bypass();
        iss_ready = 1'b0;
        drv(ALU_XOR, 1'b0, 6'd33, 1'b0, 6'd33, 1'b0, 6'd34, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 6'd33;
        tick(); idle();
        tests++; if (iss_valid !== 1'b1 || iss_dst_tag !== 6'd34 || iss_src2_tag !== 6'd33)
            begin fails++; $display("FAIL bypass got v=%0b dst=%0d s2=%0d want 1/34/33", iss_valid, iss_dst_tag, iss_src2_tag); end
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
    endtask

    task automatic test_flush();
        iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drv(ALU_ADD, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'(50 + k), 32'd0); tick();
        end
        idle();
        tests++; if (iss_valid !== 1'b1) begin fails++; $display("FAIL flush_pre got %0b want 1", iss_valid); end
        drv(ALU_ADD, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd53, 32'd0); flush = 1'b1;
        tick(); idle();
        tests++; if (iss_valid !== 1'b0 || disp_ready !== 1'b1 || iss_dst_tag !== 6'd0)
            begin fails++; $display("FAIL flush_post got v=%0b r=%0b dst=%0d want 0/1/0", iss_valid, disp_ready, iss_dst_tag); end
        tick();
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL flush_not_stored got %0b want 0", iss_valid); end
    endtask

    task automatic test_reset_mid();
        iss_ready = 1'b0;
        drv(ALU_ADD, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd62, 32'd0); tick();
        drv(ALU_ADD, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd63, 32'd0); tick(); idle();
        tests++; if (iss_valid !== 1'b1) begin fails++; $display("FAIL rmid_pre got %0b want 1", iss_valid); end
        #2 reset = 1'b1; #1;
        tests++; if (iss_valid !== 1'b0 || disp_ready !== 1'b1) begin fails++; $display("FAIL rmid_async got v=%0b r=%0b want 0/1", iss_valid, disp_ready); end
        @(negedge clk); reset = 1'b0; iss_ready = 1'b1;
        tick();
        tests++; if (iss_valid !== 1'b0) begin fails++; $display("FAIL rmid_after got %0b want 0", iss_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_fill();
        test_age();
        test_full();
        test_back_to_back();
        test_disp_bypass();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
